// File: rtl/dsp_seq_pkg.sv
// Shared constants and types for the DSP48A1 multiply-accumulate sequencer.
package dsp_seq_pkg;

  localparam logic [7:0] OPM_FIRST = 8'h0E;
  localparam logic [7:0] OPM_ACC   = 8'h06;
  localparam logic [7:0] OPM_HOLD  = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_DRAIN,
    ST_HOLD
  } state_t;

  localparam int TAG_W = 3;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

endpackage

// File: rtl/dsp_tag_pipe.sv
// Delay line that tracks each issued beat through the slice pipeline.
// stage_reg[i] holds the tag issued i+1 edges ago.
module dsp_tag_pipe
  import dsp_seq_pkg::*;
#(
  parameter int OPM_DLY = 1,
  parameter int DSP_LAT = 3
) (
  input  logic clk,
  input  logic srst,
  input  tag_t tag_in,
  output tag_t opm_tap,
  output tag_t res_tap
);

  tag_t [DSP_LAT:0] stage_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= {stage_reg[DSP_LAT-1:0], tag_in};
    end
  end

  // The result tap sits one stage past DSP_LAT so P is sampled after PREG settles.
  assign opm_tap = stage_reg[OPM_DLY-1];
  assign res_tap = stage_reg[DSP_LAT];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Feeds operand pairs into a DSP48A1 configured as a MAC and captures the
// accumulated P for each S_LAST-framed vector into a held result register.
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int DSP_LAT = 3,
  parameter int OPM_DLY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             S_VALID,
  output logic             S_READY,
  input  logic [17:0]      S_A,
  input  logic [17:0]      S_B,
  input  logic             S_LAST,
  output logic [17:0]      DSP_A,
  output logic [17:0]      DSP_B,
  output logic [7:0]       DSP_OPMODE,
  output logic             DSP_RST,
  input  logic [47:0]      DSP_P,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic [47:0]      M_DATA,
  output logic [CNT_W-1:0] M_COUNT
);

  state_t             state_reg, state_next;
  logic               s_ready_reg;
  logic [17:0]        dsp_a_reg, dsp_b_reg;
  logic [7:0]         opmode_reg;
  logic               dsp_rst_reg;
  logic               m_valid_reg;
  logic [47:0]        m_data_reg;
  logic [CNT_W-1:0]   m_count_reg, cnt_reg;

  tag_t tag_in, opm_tap, res_tap;
  logic accept, capture, tap_unused;

  assign accept  = S_VALID && s_ready_reg;
  assign capture = (state_reg == ST_DRAIN) && res_tap.valid && res_tap.last;
  assign tap_unused = opm_tap.last | res_tap.first;

  always_comb begin
    tag_in       = '0;
    tag_in.valid = accept;
    tag_in.first = accept && (state_reg == ST_IDLE);
    tag_in.last  = accept && S_LAST;
  end

  dsp_tag_pipe #(
    .OPM_DLY(OPM_DLY),
    .DSP_LAT(DSP_LAT)
  ) u_tag_pipe (
    .clk    (CLK),
    .srst   (RST),
    .tag_in (tag_in),
    .opm_tap(opm_tap),
    .res_tap(res_tap)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_ACC: if (accept) state_next = S_LAST ? ST_DRAIN : ST_ACC;
      ST_DRAIN:        if (capture) state_next = ST_HOLD;
      ST_HOLD:         if (M_READY) state_next = ST_IDLE;
      default:         state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    dsp_rst_reg <= RST;
    if (RST) begin
      state_reg   <= ST_IDLE;
      s_ready_reg <= 1'b0;
      dsp_a_reg   <= '0;
      dsp_b_reg   <= '0;
      opmode_reg  <= OPM_HOLD;
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      m_count_reg <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      s_ready_reg <= (state_next == ST_IDLE) || (state_next == ST_ACC);
      // Bubbles drive zero operands and HOLD so P never sees a stray product.
      dsp_a_reg   <= accept ? S_A : '0;
      dsp_b_reg   <= accept ? S_B : '0;
      if (!opm_tap.valid)
        opmode_reg <= OPM_HOLD;
      else
        opmode_reg <= opm_tap.first ? OPM_FIRST : OPM_ACC;
      if (accept) begin
        if (state_reg == ST_IDLE)
          cnt_reg <= CNT_W'(1);
        else if (!(&cnt_reg))
          cnt_reg <= cnt_reg + CNT_W'(1);
      end
      if (capture) begin
        m_valid_reg <= 1'b1;
        m_data_reg  <= DSP_P;
        m_count_reg <= cnt_reg;
      end else if (m_valid_reg && M_READY) begin
        m_valid_reg <= 1'b0;
      end
    end
  end

  assign S_READY    = s_ready_reg;
  assign DSP_A      = dsp_a_reg;
  assign DSP_B      = dsp_b_reg;
  assign DSP_OPMODE = opmode_reg;
  assign DSP_RST    = dsp_rst_reg;
  assign M_VALID    = m_valid_reg;
  assign M_DATA     = m_data_reg;
  assign M_COUNT    = m_count_reg;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer driving a behavioural DSP48A1 MAC slice model.
module tb_dsp_mac_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, s_valid, s_ready, s_last, dsp_rst, m_valid, m_ready;
  logic [17:0] s_a, s_b, dsp_a, dsp_b;
  logic [7:0]  dsp_opmode;
  logic [47:0] dsp_p, m_data;
  logic [15:0] m_count;

  dsp_mac_sequencer dut (
    .CLK(clk), .RST(rst), .S_VALID(s_valid), .S_READY(s_ready),
    .S_A(s_a), .S_B(s_b), .S_LAST(s_last),
    .DSP_A(dsp_a), .DSP_B(dsp_b), .DSP_OPMODE(dsp_opmode), .DSP_RST(dsp_rst),
    .DSP_P(dsp_p), .M_VALID(m_valid), .M_READY(m_ready),
    .M_DATA(m_data), .M_COUNT(m_count)
  );

  // Slice model: A1/B1 regs, MREG, OPMODEREG, PREG.
  logic [17:0] a1_q, b1_q;
  logic [35:0] m_q;
  logic [7:0]  opm_q;
  logic [47:0] p_q;
  always @(posedge clk) begin
    if (dsp_rst) begin
      a1_q <= '0; b1_q <= '0; m_q <= '0; opm_q <= 8'h07; p_q <= '0;
    end else begin
      a1_q  <= dsp_a;
      b1_q  <= dsp_b;
      m_q   <= a1_q * b1_q;
      opm_q <= dsp_opmode;
      case (opm_q)
        8'h0E:   p_q <= {12'd0, m_q};
        8'h06:   p_q <= p_q + {12'd0, m_q};
        default: p_q <= p_q;
      endcase
    end
  end
  assign dsp_p = p_q;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [47:0] data;
    logic [15:0] count;
    int          cyc;
  } obs_t;
  obs_t res_q[$];

  // Monitor: collects results and checks OPMODE against the accept history.
  logic       trk_en = 1'b0, tb_first = 1'b0;
  logic       acc_d1 = 1'b0, acc_d2 = 1'b0, first_d1 = 1'b0, first_d2 = 1'b0, rst_d1 = 1'b0;
  logic [7:0] exp_opm;
  int         opm_bad = 0, n_first_opm = 0;
  always @(negedge clk) begin
    if (trk_en) begin
      exp_opm = rst_d1 ? 8'h07 : (acc_d2 ? (first_d2 ? 8'h0E : 8'h06) : 8'h07);
      if (dsp_opmode !== exp_opm) opm_bad++;
      if (dsp_opmode == 8'h0E) n_first_opm++;
      if (m_valid && m_ready) res_q.push_back('{m_data, m_count, cyc});
      acc_d2   = acc_d1;
      first_d2 = first_d1;
      acc_d1   = s_valid && s_ready && !rst;
      first_d1 = tb_first;
      rst_d1   = rst;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [17:0] a, input logic [17:0] b, input logic last,
                      input logic first, output int acc_cyc);
    int n = 0;
    s_a = a; s_b = b; s_last = last; tb_first = first; s_valid = 1'b1;
    while (!s_ready && n < 200) begin tick(1); n++; end
    acc_cyc = -1;
    if (!s_ready) begin
      check("send_ready_timeout", {63'd0, s_ready}, 64'd1);
    end else begin
      tick(1);
      acc_cyc = cyc;
    end
    s_valid = 1'b0; s_last = 1'b0; tb_first = 1'b0;
  endtask

  task automatic wait_res(input int n, input string name);
    int t = 0;
    while (res_q.size() < n && t < 100) begin tick(1); t++; end
    check(name, 64'(res_q.size()), 64'(n));
  endtask

  typedef struct {
    logic [17:0] a;
    logic [17:0] b;
    logic        last;
    int          gap;
  } beat_t;
  typedef struct {
    logic [47:0] data;
    logic [15:0] count;
  } res_t;

  beat_t beats[11];
  res_t  exp_res[5];
  int    last_acc[5];

  initial begin
    int    acc_c, vi, mv_seen;
    logic  first;
    beats[0]  = '{18'd3,   18'd4,   1'b0, 0};
    beats[1]  = '{18'd5,   18'd6,   1'b0, 0};
    beats[2]  = '{18'd7,   18'd8,   1'b1, 0};
    beats[3]  = '{18'd100, 18'd200, 1'b1, 0};
    beats[4]  = '{18'd3,   18'd4,   1'b0, 0};
    beats[5]  = '{18'd5,   18'd6,   1'b0, 2};
    beats[6]  = '{18'd7,   18'd8,   1'b1, 2};
    beats[7]  = '{18'd1,   18'd1,   1'b0, 0};
    beats[8]  = '{18'd2,   18'd2,   1'b1, 0};
    beats[9]  = '{18'd3,   18'd3,   1'b1, 0};
    beats[10] = '{18'd0,   18'd0,   1'b0, 0};
    exp_res[0] = '{48'd98,    16'd3};
    exp_res[1] = '{48'd20000, 16'd1};
    exp_res[2] = '{48'd98,    16'd3};
    exp_res[3] = '{48'd5,     16'd2};
    exp_res[4] = '{48'd9,     16'd1};

    rst = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0; m_ready = 1'b1;
    tick(3);
    check("rst_s_ready",  {63'd0, s_ready}, 64'd0);
    check("rst_m_valid",  {63'd0, m_valid}, 64'd0);
    check("rst_m_data",   {16'd0, m_data},  64'd0);
    check("rst_m_count",  {48'd0, m_count}, 64'd0);
    check("rst_dsp_a",    {46'd0, dsp_a},   64'd0);
    check("rst_dsp_b",    {46'd0, dsp_b},   64'd0);
    check("rst_opmode",   {56'd0, dsp_opmode}, 64'h07);
    check("rst_dsp_rst",  {63'd0, dsp_rst}, 64'd1);
    rst = 1'b0;
    tick(1);
    check("post_rst_dsp_rst", {63'd0, dsp_rst}, 64'd0);
    check("post_rst_s_ready", {63'd0, s_ready}, 64'd1);
    trk_en = 1'b1;

    // Table run: five vectors with M_READY held high.
    n_first_opm = 0;
    first = 1'b1;
    vi = 0;
    for (int i = 0; i < 10; i++) begin
      tick(beats[i].gap);
      send(beats[i].a, beats[i].b, beats[i].last, first, acc_c);
      first = beats[i].last;
      if (beats[i].last) begin last_acc[vi] = acc_c; vi++; end
    end
    wait_res(5, "table_result_count");
    tick(2);
    check("table_extra_results", 64'(res_q.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < res_q.size()) begin
        check($sformatf("vec%0d_data", i),    {16'd0, res_q[i].data},  {16'd0, exp_res[i].data});
        check($sformatf("vec%0d_count", i),   {48'd0, res_q[i].count}, {48'd0, exp_res[i].count});
        check($sformatf("vec%0d_latency", i), 64'(res_q[i].cyc - last_acc[i]), 64'd4);
      end
    end
    check("opmode_first_cycles", 64'(n_first_opm), 64'd5);
    res_q.delete();

    // Max operands with back-pressure on the result port.
    m_ready = 1'b0;
    send(18'h3FFFF, 18'h3FFFF, 1'b1, 1'b1, acc_c);
    mv_seen = 0;
    while (!m_valid && mv_seen < 20) begin tick(1); mv_seen++; end
    check("hold_latency", 64'(cyc - acc_c), 64'd4);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d_m_valid", i), {63'd0, m_valid}, 64'd1);
      check($sformatf("hold%0d_m_data", i),  {16'd0, m_data},  64'd68718952449);
      check($sformatf("hold%0d_s_ready", i), {63'd0, s_ready}, 64'd0);
      tick(1);
    end
    check("hold_m_count", {48'd0, m_count}, 64'd1);
    m_ready = 1'b1;
    tick(1);
    check("release_m_valid", {63'd0, m_valid}, 64'd0);
    check("release_s_ready", {63'd0, s_ready}, 64'd1);
    tick(1);
    res_q.delete();

    // Reset after the 2nd beat of a 3-beat vector: nothing may emerge.
    send(18'd3, 18'd4, 1'b0, 1'b1, acc_c);
    send(18'd5, 18'd6, 1'b0, 1'b0, acc_c);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    mv_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (m_valid) mv_seen++;
      tick(1);
    end
    check("midrst_no_m_valid", 64'(mv_seen), 64'd0);
    check("midrst_no_result",  64'(res_q.size()), 64'd0);
    send(18'd2, 18'd3, 1'b1, 1'b1, acc_c);
    wait_res(1, "after_rst_result_count");
    if (res_q.size() > 0) begin
      check("after_rst_data",  {16'd0, res_q[0].data},  64'd6);
      check("after_rst_count", {48'd0, res_q[0].count}, 64'd1);
    end
    tick(3);
    check("opmode_track_errors", 64'(opm_bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

endmodule
